// File: rtl/filter_timing_ctrl.sv
// Frame scheduler and raster timing generator feeding vs/hs/de and pixel
// coordinates to the image-filter pipeline under a start/stop/done handshake.
module filter_timing_ctrl #(
  parameter int unsigned HSW      = 1,
  parameter int unsigned HBP      = 3,
  parameter int unsigned HAC      = 1920,
  parameter int unsigned HFP      = 3,
  parameter int unsigned VSW      = 1,
  parameter int unsigned VBP      = 3,
  parameter int unsigned VAC      = 1080,
  parameter int unsigned VFP      = 3,
  parameter int unsigned CNT_SIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [7:0]          i_frame_num,
  output logic                o_vs,
  output logic                o_hs,
  output logic                o_de,
  output logic [CNT_SIZE-1:0] o_x,
  output logic [CNT_SIZE-1:0] o_y,
  output logic                o_busy,
  output logic                o_done,
  output logic [7:0]          o_frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_SIZE-1:0] H_SW   = CNT_SIZE'(HSW);
  localparam logic [CNT_SIZE-1:0] H_DE_S = CNT_SIZE'(HSW + HBP);
  localparam logic [CNT_SIZE-1:0] H_DE_E = CNT_SIZE'(HSW + HBP + HAC - 1);
  localparam logic [CNT_SIZE-1:0] H_LAST = CNT_SIZE'(HSW + HBP + HAC + HFP - 1);
  localparam logic [CNT_SIZE-1:0] V_SW   = CNT_SIZE'(VSW);
  localparam logic [CNT_SIZE-1:0] V_DE_S = CNT_SIZE'(VSW + VBP);
  localparam logic [CNT_SIZE-1:0] V_DE_E = CNT_SIZE'(VSW + VBP + VAC - 1);
  localparam logic [CNT_SIZE-1:0] V_LAST = CNT_SIZE'(VSW + VBP + VAC + VFP - 1);

  logic [1:0]          r_state;
  logic [CNT_SIZE-1:0] r_h;
  logic [CNT_SIZE-1:0] r_v;
  logic                r_stop_req;
  logic [7:0]          r_frm_tgt;

  logic                w_hs;
  logic                w_vs;
  logic                w_de;
  logic                w_h_end;
  logic                w_frame_end;
  logic [7:0]          w_frame_cnt_nxt;
  logic                w_finish;

  assign w_hs            = (r_h < H_SW);
  assign w_vs            = (r_v < V_SW);
  assign w_de            = (r_h >= H_DE_S) && (r_h <= H_DE_E) &&
                           (r_v >= V_DE_S) && (r_v <= V_DE_E);
  assign w_h_end         = (r_h == H_LAST);
  assign w_frame_end     = w_h_end && (r_v == V_LAST);
  assign w_frame_cnt_nxt = o_frame_cnt + 8'd1;
  // A stop arriving on the frame-end cycle itself still ends this frame.
  assign w_finish        = r_stop_req || i_stop ||
                           ((r_frm_tgt != 8'd0) && (w_frame_cnt_nxt == r_frm_tgt));

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_stop_req  <= 1'b0;
      r_frm_tgt   <= '0;
      o_vs        <= 1'b0;
      o_hs        <= 1'b0;
      o_de        <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_done      <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      if (r_state == S_RUN) begin
        o_vs <= w_vs;
        o_hs <= w_hs;
        o_de <= w_de;
        o_x  <= w_de ? (r_h - H_DE_S) : '0;
        o_y  <= w_de ? (r_v - V_DE_S) : '0;
      end else begin
        o_vs <= 1'b0;
        o_hs <= 1'b0;
        o_de <= 1'b0;
        o_x  <= '0;
        o_y  <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_h         <= '0;
            r_v         <= '0;
            r_stop_req  <= 1'b0;
            r_frm_tgt   <= i_frame_num;
            o_frame_cnt <= '0;
          end
        end
        S_RUN: begin
          if (i_stop) r_stop_req <= 1'b1;
          if (w_frame_end) begin
            r_h         <= '0;
            r_v         <= '0;
            o_frame_cnt <= w_frame_cnt_nxt;
            if (w_finish) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end
          end else if (w_h_end) begin
            r_h <= '0;
            r_v <= r_v + 1'b1;
          end else begin
            r_h <= r_h + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_timing_ctrl.sv
// Directed bench for filter_timing_ctrl on a 13x7 raster (91 cycles per frame).
module tb_filter_timing_ctrl;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_stop;
  logic [7:0]  i_frame_num;
  logic        o_vs;
  logic        o_hs;
  logic        o_de;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int last_x;
  int last_y;

  filter_timing_ctrl #(
    .HSW(1), .HBP(2), .HAC(8), .HFP(2),
    .VSW(1), .VBP(1), .VAC(4), .VFP(1),
    .CNT_SIZE(12)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_frame_num(i_frame_num), .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .o_x(o_x), .o_y(o_y), .o_busy(o_busy), .o_done(o_done),
    .o_frame_cnt(o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {5'b0, o_vs, o_hs, o_de, o_x, o_y};
  endfunction

  // Call with i_start already driven; cycle c counts edges after the start edge.
  task automatic run_seq(input int nfr, input int ncyc, input int stop_at,
                         input int poke_at, input int exp_de, input int exp_done);
    int p, h, v, de_cnt, first_de, vs_rise;
    logic prev_vs, ehs, evs, ede;
    logic [31:0] eo;
    de_cnt = 0; first_de = -1; vs_rise = 0; prev_vs = 1'b0;
    tick();
    i_start = 1'b0;
    i_stop  = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        tick();
        if (c == stop_at) i_stop = 1'b0;
        if (c == poke_at) i_start = 1'b0;
      end
      eo = '0;
      if (c >= 1 && c <= 91 * nfr) begin
        p   = (c - 1) % 91;
        h   = p % 13;
        v   = p / 13;
        ehs = (h < 1);
        evs = (v < 1);
        ede = (h >= 3 && h <= 10 && v >= 2 && v <= 5);
        eo  = {5'b0, evs, ehs, ede, (ede ? 12'(h - 3) : 12'd0), (ede ? 12'(v - 2) : 12'd0)};
      end
      chk("raster", outs(), eo);
      chk("busy", o_busy, (c <= exp_done));
      chk("done", o_done, (c == exp_done));
      if (o_de) begin
        de_cnt++;
        if (first_de < 0) first_de = c;
        last_x = o_x;
        last_y = o_y;
      end
      if (o_vs && !prev_vs) vs_rise++;
      prev_vs = o_vs;
      if (c == stop_at - 1) i_stop = 1'b1;
      if (c == poke_at - 1) begin
        i_start     = 1'b1;
        i_frame_num = 8'd1;
      end
    end
    chk("de_count", de_cnt, exp_de);
    chk("first_de", first_de, 30);
    chk("vs_pulses", vs_rise, nfr);
    chk("frame_cnt", o_frame_cnt, nfr);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_frame_num = 8'd0;
    tick(); tick();
    chk("rst_outs", outs(), 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    rst = 1'b0;
    tick();

    // Single frame
    i_frame_num = 8'd1; i_start = 1'b1;
    run_seq(1, 95, -1, -1, 32, 91);
    chk("single_last_x", last_x, 7);
    chk("single_last_y", last_y, 3);
    tick(); tick(); tick();
    chk("hold_fcnt", o_frame_cnt, 1);
    chk("hold_busy", o_busy, 0);

    // Multi-frame; start + frame_num change mid-run must be ignored
    i_frame_num = 8'd3; i_start = 1'b1;
    run_seq(3, 280, -1, 100, 96, 273);
    chk("multi_last_y", last_y, 3);
    tick();

    // Continuous with stop at cycle 150
    i_frame_num = 8'd0; i_start = 1'b1;
    run_seq(2, 190, 150, -1, 64, 182);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    tick(); tick(); tick();
    chk("idle_stop_busy", o_busy, 0);
    chk("idle_stop_outs", outs(), 0);
    chk("idle_stop_fcnt", o_frame_cnt, 2);

    // Reset mid-frame at cycle 40
    i_frame_num = 8'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 39; c++) begin
      tick();
      if (c == 30) chk("pre_rst_de", {o_de, o_x, o_y}, 25'h1000000);
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", outs(), 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_fcnt", o_frame_cnt, 0);
    rst = 1'b0;
    tick();
    i_frame_num = 8'd1; i_start = 1'b1;
    run_seq(1, 95, -1, -1, 32, 91);

    // Start and stop together in IDLE: start wins, runs both frames
    tick();
    i_frame_num = 8'd2; i_start = 1'b1; i_stop = 1'b1;
    run_seq(2, 190, -1, -1, 64, 182);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
